// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, SETTLE, DRAIN)
//   BYTE_W      : width of one transmitted byte
//   LOCK_CNT_W  : width of the lock-timeout counter
// ----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int BYTE_W     = 8;
  localparam int LOCK_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // arbitrate when the transmitter is free
    ISSUE  = 2'd1,  // one-cycle write strobe and requester ack
    SETTLE = 2'd2,  // transmitter raises busy during this cycle
    DRAIN  = 2'd3   // wait for the transmitter to finish the byte
  } arb_state_t;

endpackage : uart_arb_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request found
// searching upward from ptr, wrapping modulo NREQ (not modulo 2**IDX_W).
//   req   in  NREQ   request vector
//   ptr   in  IDX_W  highest-priority index for this search
//   valid out 1      at least one request asserted
//   idx   out IDX_W  winning index (0 when valid is low)
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk the rotated order from the far end back to ptr so that the last
  // hit written is the one closest to ptr.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one byte transmitter (wb_uart_tx) between NREQ byte sources. A
// requester wins round-robin and keeps the transmitter for a whole frame,
// i.e. until a byte flagged last has drained. A locked owner that stops
// requesting for LOCK_TIMEOUT idle cycles loses the lock.
//   i_clk         in   system clock
//   i_rst_n       in   asynchronous active-low reset
//   i_req         in   NREQ      per-requester byte valid (level)
//   i_data        in   NREQ*8    requester k uses bits [8k+7:8k]
//   i_last        in   NREQ      byte ends the requester's frame
//   o_ack         out  NREQ      one-cycle pulse, byte consumed
//   o_grant       out  NREQ      one-hot transmitter owner, 0 when free
//   o_lock_abort  out  1         one-cycle pulse, lock broken by timeout
//   o_tx_wr       out  1         transmitter write strobe
//   o_tx_data     out  8         transmitter byte
//   i_tx_busy     in   1         transmitter busy
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int                    NREQ         = 4,
  parameter logic [LOCK_CNT_W-1:0] LOCK_TIMEOUT = 16'd4096
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*BYTE_W-1:0] i_data,
  input  logic [NREQ-1:0]        i_last,
  output logic [NREQ-1:0]        o_ack,
  output logic [NREQ-1:0]        o_grant,
  output logic                   o_lock_abort,
  output logic                   o_tx_wr,
  output logic [BYTE_W-1:0]      o_tx_data,
  input  logic                   i_tx_busy
);

  localparam int IDX_W = $clog2(NREQ);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t              state_q,   state_d;
  logic [NREQ-1:0]         grant_q,   grant_d;
  logic [IDX_W-1:0]        owner_q,   owner_d;
  logic [BYTE_W-1:0]       tx_data_q, tx_data_d;
  logic                    last_q,    last_d;
  logic                    lock_q,    lock_d;
  logic [IDX_W-1:0]        rr_ptr_q,  rr_ptr_d;
  logic [LOCK_CNT_W-1:0]   cnt_q,     cnt_d;

  // --------------------------------------------------------------------------
  // Selection
  // --------------------------------------------------------------------------
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              owner_req;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;
  logic [BYTE_W-1:0] sel_data;
  logic              sel_last;

  logic [LOCK_CNT_W-1:0] cnt_inc;
  logic                  lock_abort;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (i_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // While a frame is locked only the owner may be picked; the round-robin
  // result is ignored.
  assign owner_req = i_req[owner_q];
  assign sel_valid = lock_q ? owner_req : pick_valid;
  assign sel_idx   = lock_q ? owner_q   : pick_idx;
  assign sel_last  = i_last[sel_idx];

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel_idx == IDX_W'(k)) begin
        sel_data = i_data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Saturating increment; the abort fires on the cycle the count would reach
  // LOCK_TIMEOUT, so the abort is the LOCK_TIMEOUT-th idle cycle. A pending
  // owner request always beats the timeout.
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign lock_abort = (state_q == IDLE) && lock_q && !owner_req &&
                      (cnt_inc == LOCK_TIMEOUT);

  // Explicit wrap at NREQ-1 so non-power-of-two NREQ never yields an index
  // past the last requester.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      lock_q    <= 1'b0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    lock_d    = lock_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (lock_q) begin
          if (owner_req) begin
            cnt_d = '0;
          end else if (lock_abort) begin
            lock_d   = 1'b0;
            grant_d  = '0;
            rr_ptr_d = wrap_inc(owner_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        // A transmitter still busy (e.g. after a reset mid-byte) blocks
        // arbitration entirely.
        if (!i_tx_busy && sel_valid) begin
          state_d          = ISSUE;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          owner_d          = sel_idx;
          tx_data_d        = sel_data;
          last_d           = sel_last;
        end
      end

      ISSUE:  state_d = SETTLE;

      // Busy is not valid yet in the cycle after the strobe; skip it.
      SETTLE: state_d = DRAIN;

      DRAIN: begin
        if (!i_tx_busy) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (last_q) begin
            lock_d   = 1'b0;
            grant_d  = '0;
            rr_ptr_d = wrap_inc(owner_q);
          end else begin
            lock_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_tx_wr = 1'b0;
    o_ack   = '0;
    if (state_q == ISSUE) begin
      o_tx_wr = 1'b1;
      o_ack   = grant_q;
    end
  end

  assign o_grant      = grant_q;
  assign o_tx_data    = tx_data_q;
  assign o_lock_abort = lock_abort;

endmodule : uart_tx_arbiter
